// File: rtl/exibe_sequencia.sv
// -----------------------------------------------------------------------------
// exibe_sequencia
//
// Presentation engine for the memory game. It replays the stored sequence
// from a synchronous 16x4 ROM, starting at address 0 and stopping at the
// limit captured on start. Each entry is lit on the LEDs for T_ON cycles and
// then blanked for T_OFF cycles. A single-cycle pulse on 'pronto' marks the
// end of the sequence.
//
// Ports:
//   clock      in   1  system clock, rising-edge
//   reset      in   1  synchronous, active-high reset
//   iniciar    in   1  start request, honoured only while idle
//   limite     in   4  last address to show (inclusive), captured on start
//   dado       in   4  ROM read data, valid one cycle after endereco is sampled
//   endereco   out  4  ROM address
//   leds       out  4  latched entry while lit, 0 otherwise
//   ocupado    out  1  high whenever the engine is not idle
//   pronto     out  1  one-cycle end-of-sequence pulse
//   db_estado  out  4  current state code (debug)
// -----------------------------------------------------------------------------
module exibe_sequencia #(
    parameter int T_ON  = 500,
    parameter int T_OFF = 250,
    parameter int CW    = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam logic [3:0] OCIOSO   = 4'd0;
    localparam logic [3:0] ENDERECA = 4'd1;
    localparam logic [3:0] CARREGA  = 4'd2;
    localparam logic [3:0] ACENDE   = 4'd3;
    localparam logic [3:0] APAGA    = 4'd4;
    localparam logic [3:0] PROXIMO  = 4'd5;
    localparam logic [3:0] FIM      = 4'd6;

    // Terminal counts: the counter runs 0..T-1, so a phase lasts exactly T cycles.
    localparam logic [CW-1:0] ON_LAST  = CW'(T_ON - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(T_OFF - 1);

    logic [3:0]    r_estado;
    logic [3:0]    r_endereco;
    logic [3:0]    r_limite;
    logic [3:0]    r_dado;
    logic [CW-1:0] r_cnt;

    logic w_acende;
    logic w_ultimo;

    function automatic logic fim_fase(input logic [CW-1:0] cnt, input logic [CW-1:0] last);
        return cnt == last;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_endereco <= 4'd0;
            r_limite   <= 4'd0;
            r_dado     <= 4'd0;
            r_cnt      <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (iniciar) begin
                        r_endereco <= 4'd0;
                        r_limite   <= limite;
                        r_estado   <= ENDERECA;
                    end
                end
                // The ROM samples endereco at the closing edge of this cycle.
                ENDERECA: r_estado <= CARREGA;
                CARREGA: begin
                    r_dado   <= dado;
                    r_cnt    <= '0;
                    r_estado <= ACENDE;
                end
                ACENDE: begin
                    if (fim_fase(r_cnt, ON_LAST)) begin
                        r_cnt    <= '0;
                        r_estado <= APAGA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                APAGA: begin
                    if (fim_fase(r_cnt, OFF_LAST)) begin
                        r_cnt    <= '0;
                        r_estado <= PROXIMO;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                // Compare before incrementing so limite=15 never wraps the address.
                PROXIMO: begin
                    if (w_ultimo) begin
                        r_estado <= FIM;
                    end else begin
                        r_endereco <= r_endereco + 4'd1;
                        r_estado   <= ENDERECA;
                    end
                end
                FIM:     r_estado <= OCIOSO;
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign w_acende  = (r_estado == ACENDE);
    assign w_ultimo  = (r_endereco == r_limite);

    // A stored 0000 still occupies its full lit slot; it simply looks dark.
    assign leds      = w_acende ? r_dado : 4'd0;
    assign endereco  = r_endereco;
    assign ocupado   = (r_estado != OCIOSO);
    assign pronto    = (r_estado == FIM);
    assign db_estado = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
module tb_exibe_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int CW    = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .CW(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .limite   (limite),
        .dado     (dado),
        .endereco (endereco),
        .leds     (leds),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .db_estado(db_estado)
    );

    // Synchronous 16x4 ROM model: data appears one cycle after the address.
    logic [3:0] rom [16];
    always @(posedge clock) dado <= rom[endereco];

    // Observation record: {state, leds, endereco, ocupado, pronto}
    typedef logic [13:0] obs_t;
    obs_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] idle_addr = 4'd0;
    logic       mon_en = 1'b0;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         pronto_cyc = -1;
    int         pronto_count = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one observation per cycle, popped from the scoreboard while a
    // sequence is expected, otherwise the engine must sit idle.
    always @(negedge clock) begin
        if (mon_en) begin
            obs_t act;
            obs_t e;
            act = {db_estado, leds, endereco, ocupado, pronto};
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = {4'd0, 4'd0, idle_addr, 1'b0, 1'b0};
            check("cycle_obs", 32'(act), 32'(e));
            if (pronto === 1'b1) begin
                pronto_cyc = cyc;
                pronto_count++;
            end
        end
    end

    // Reference model: the expected cycle-by-cycle presentation of a sequence.
    task automatic build(input logic [3:0] lim);
        for (int a = 0; a <= int'(lim); a++) begin
            logic [3:0] a4;
            a4 = 4'(a);
            exp_q.push_back({4'd1, 4'd0, a4, 1'b1, 1'b0});
            exp_q.push_back({4'd2, 4'd0, a4, 1'b1, 1'b0});
            for (int k = 0; k < T_ON; k++) exp_q.push_back({4'd3, rom[a4], a4, 1'b1, 1'b0});
            for (int k = 0; k < T_OFF; k++) exp_q.push_back({4'd4, 4'd0, a4, 1'b1, 1'b0});
            exp_q.push_back({4'd5, 4'd0, a4, 1'b1, 1'b0});
        end
        exp_q.push_back({4'd6, 4'd0, lim, 1'b1, 1'b1});
        idle_addr = lim;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [3:0] lim);
        iniciar = 1'b1;
        limite  = lim;
        tick();
        iniciar = 1'b0;
        accept_cyc   = cyc;
        pronto_count = 0;
        pronto_cyc   = -1;
        build(lim);
    endtask

    task automatic finish_seq(input logic [3:0] lim);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        check("pronto_count", 32'(pronto_count), 32'd1);
        check("pronto_latency", 32'(pronto_cyc - accept_cyc + 1),
              32'((int'(lim) + 1) * (T_ON + T_OFF + 3) + 1));
    endtask

    task automatic run_seq(input logic [3:0] lim, input bit disturb);
        start(lim);
        if (disturb) begin
            repeat (9) tick();          // now inside entry 1
            iniciar = 1'b1;
            limite  = ~lim;
            tick();
            iniciar = 1'b0;
        end
        finish_seq(lim);
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        limite  = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = 4'd0;
        tick();
        tick();
        mon_en = 1'b1;
        check("reset_state", 32'(db_estado), 32'd0);
        check("reset_leds", 32'(leds), 32'd0);
        reset = 1'b0;
        repeat (10) tick();

        // Three-entry sequence 1,2,4
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4;
        run_seq(4'd2, 1'b0);

        // Single entry
        rom[0] = 4'd8;
        run_seq(4'd0, 1'b0);
        check("hold_addr_lim0", 32'(endereco), 32'd0);

        // Full 16-entry sequence, no wrap
        for (int i = 0; i < 16; i++) rom[i] = 4'hF;
        run_seq(4'd15, 1'b0);
        check("hold_addr_lim15", 32'(endereco), 32'd15);

        // Zero entry is shown dark, not skipped
        rom[0] = 4'd5; rom[1] = 4'd0;
        run_seq(4'd1, 1'b0);

        // Restart request and limit change mid-sequence are ignored
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
        run_seq(4'd3, 1'b1);

        // Reset during entry 1 lit phase aborts without pronto
        start(4'd4);
        repeat (12) tick();             // entry 1 lit phase
        check("abort_pre_state", 32'(db_estado), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        idle_addr = 4'd0;
        check("abort_state", 32'(db_estado), 32'd0);
        check("abort_leds", 32'(leds), 32'd0);
        check("abort_addr", 32'(endereco), 32'd0);
        repeat (60) tick();
        check("abort_no_pronto", 32'(pronto_count), 32'd0);

        // Randomised sequences
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
            run_seq(4'($urandom_range(0, 15)), n[0]);
            repeat ($urandom_range(0, 4)) tick();
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
